// File: rtl/clock_segment_recorder_if.sv
// Signal/host-side bundle of the clock segment recorder: measured input, host triggers,
// FIFO back-pressure and the 128-bit segment word stream.
interface clock_segment_recorder_if;
    logic         sig_in;
    logic         arm;
    logic         abort;
    logic         fifo_full;
    logic [127:0] seg_data;
    logic         seg_write;
    logic         busy;
    logic         done;
    logic         overflow;

    modport master (
        output sig_in, arm, abort, fifo_full,
        input  seg_data, seg_write, busy, done, overflow
    );

    modport slave (
        input  sig_in, arm, abort, fifo_full,
        output seg_data, seg_write, busy, done, overflow
    );
endinterface

// File: rtl/clock_segment_recorder.sv
// Measures a pulse train and run-length encodes its periods into {on, off, repeat}
// segment words for the segment FIFO.
module clock_segment_recorder #(
    parameter int ON_W         = 48,
    parameter int OFF_W        = 48,
    parameter int REP_W        = 32,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic                     refclk,
    input  logic                     reset,
    clock_segment_recorder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        LOW,
        FLUSH
    } state_t;

    localparam logic [ON_W-1:0]  ON_MAX    = '1;
    localparam logic [REP_W-1:0] REP_MAX   = '1;
    localparam logic [OFF_W-1:0] L_LAST    = OFF_W'(IDLE_TIMEOUT - 1);
    localparam logic [OFF_W-1:0] L_TIMEOUT = OFF_W'(IDLE_TIMEOUT);

    state_t             state_reg, state_next;
    logic               sync_reg, s_reg;
    logic [ON_W-1:0]    h_reg, h_next;
    logic [OFF_W-1:0]   l_reg, l_next;
    logic               pend_valid_reg, pend_valid_next;
    logic [ON_W-1:0]    pend_on_reg, pend_on_next;
    logic [OFF_W-1:0]   pend_off_reg, pend_off_next;
    logic [REP_W-1:0]   pend_rep_reg, pend_rep_next;
    logic               seg_write_reg, seg_write_next;
    logic [127:0]       seg_data_reg, seg_data_next;
    logic               done_reg, done_next;
    logic               overflow_reg, overflow_next;

    logic               close_period;
    logic [OFF_W-1:0]   close_off;
    logic               write_req;

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            sync_reg <= 1'b0;
            s_reg    <= 1'b0;
        end else begin
            sync_reg <= bus.sig_in;
            s_reg    <= sync_reg;
        end
    end

    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            h_reg          <= '0;
            l_reg          <= '0;
            pend_valid_reg <= 1'b0;
            pend_on_reg    <= '0;
            pend_off_reg   <= '0;
            pend_rep_reg   <= '0;
            seg_write_reg  <= 1'b0;
            seg_data_reg   <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            h_reg          <= h_next;
            l_reg          <= l_next;
            pend_valid_reg <= pend_valid_next;
            pend_on_reg    <= pend_on_next;
            pend_off_reg   <= pend_off_next;
            pend_rep_reg   <= pend_rep_next;
            seg_write_reg  <= seg_write_next;
            seg_data_reg   <= seg_data_next;
            done_reg       <= done_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        h_next          = h_reg;
        l_next          = l_reg;
        pend_valid_next = pend_valid_reg;
        pend_on_next    = pend_on_reg;
        pend_off_next   = pend_off_reg;
        pend_rep_next   = pend_rep_reg;
        seg_write_next  = 1'b0;
        seg_data_next   = seg_data_reg;
        done_next       = 1'b0;
        overflow_next   = overflow_reg;
        close_period    = 1'b0;
        close_off       = l_reg;
        write_req       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.arm && !bus.abort) begin
                    state_next      = WAIT_LOW;
                    overflow_next   = 1'b0;
                    pend_valid_next = 1'b0;
                    pend_on_next    = '0;
                    pend_off_next   = '0;
                    pend_rep_next   = '0;
                    h_next          = '0;
                    l_next          = '0;
                end
            end
            WAIT_LOW: begin
                if (!s_reg) state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                // Only reachable after s was seen low, so s=1 here is a rising edge.
                if (s_reg) begin
                    state_next = HIGH;
                    h_next     = ON_W'(1);
                end
            end
            HIGH: begin
                if (s_reg) begin
                    if (h_reg != ON_MAX) h_next = h_reg + 1'b1;
                end else begin
                    state_next = LOW;
                    l_next     = OFF_W'(1);
                end
            end
            LOW: begin
                if (s_reg) begin
                    close_period = 1'b1;
                    close_off    = l_reg;
                    state_next   = HIGH;
                    h_next       = ON_W'(1);
                end else if (l_reg == L_LAST) begin
                    close_period = 1'b1;
                    close_off    = L_TIMEOUT;
                    l_next       = L_TIMEOUT;
                    state_next   = FLUSH;
                end else begin
                    l_next = l_reg + 1'b1;
                end
            end
            FLUSH: begin
                write_req       = 1'b1;
                done_next       = 1'b1;
                pend_valid_next = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Merge the closed period into the pending segment, emitting the old one on a change.
        if (close_period) begin
            if (pend_valid_reg && pend_on_reg == h_reg && pend_off_reg == close_off
                    && pend_rep_reg != REP_MAX) begin
                pend_rep_next = pend_rep_reg + 1'b1;
            end else begin
                write_req       = pend_valid_reg;
                pend_valid_next = 1'b1;
                pend_on_next    = h_reg;
                pend_off_next   = close_off;
                pend_rep_next   = REP_W'(1);
            end
        end

        if (write_req) begin
            if (!bus.fifo_full) begin
                seg_write_next = 1'b1;
                seg_data_next  = {pend_on_reg, pend_off_reg, pend_rep_reg};
            end else begin
                overflow_next = 1'b1;
            end
        end

        if (state_reg != IDLE && bus.abort) begin
            state_next      = IDLE;
            pend_valid_next = 1'b0;
            seg_write_next  = 1'b0;
            seg_data_next   = seg_data_reg;
            done_next       = 1'b0;
            overflow_next   = overflow_reg;
        end
    end

    assign bus.seg_write = seg_write_reg;
    assign bus.seg_data  = seg_data_reg;
    assign bus.done      = done_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: doc/clock_segment_recorder.md
# clock_segment_recorder

Measures an externally supplied pulse train on `refclk` and encodes it into the same 128-bit clock-segment words the variable-frequency clock generator consumes: {on_counts[47:0], off_counts[47:0], repeat_counts[31:0]}. Runs of identical periods are merged into one segment. Words are written to a segment FIFO for readback by the host, so a captured waveform can be verified or replayed. Sits between a `ybus` input pin and the host-readback FIFO / pipe-out path.

## Interface
- `ON_W`, 48, on_counts field width (bits 127:80)
- `OFF_W`, 48, off_counts field width (bits 79:32)
- `REP_W`, 32, repeat_counts field width (bits 31:0); `ON_W+OFF_W+REP_W` must equal 128
- `IDLE_TIMEOUT`, 1000000, consecutive low cycles that end a capture (≥2)

Ports:
- `refclk` in 1 — sole clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `sig_in` in 1 — measured signal, asynchronous to `refclk`
- `arm` in 1 — one-cycle start pulse (host trigger)
- `abort` in 1 — one-cycle abort pulse (host trigger)
- `fifo_full` in 1 — segment FIFO full flag
- `seg_data` out 128 — segment word, valid only while `seg_write`=1
- `seg_write` out 1 — one-cycle FIFO write strobe
- `busy` out 1 — high from accepted `arm` until capture ends
- `done` out 1 — one-cycle pulse on normal completion
- `overflow` out 1 — sticky: a word was dropped due to `fifo_full`

## Operation
- `sig_in` passes through a 2-FF synchronizer; all logic uses the synchronized signal `s`. Rising edge = `s` 0→1 between consecutive cycles.
- States: IDLE, WAIT_LOW, WAIT_RISE, HIGH, LOW, FLUSH.
- IDLE: `busy`=0. `arm` → WAIT_LOW; clears `overflow`, pending segment, counters.
- WAIT_LOW: wait for `s`=0 (discards a partial high pulse) → WAIT_RISE. WAIT_RISE: wait indefinitely for a rising edge → HIGH with H=1.
- HIGH: H++ per cycle with `s`=1 (saturate at 2^ON_W−1); `s`=0 → LOW with L=1.
- LOW: L++ per cycle with `s`=0. Rising edge closes period (H,L) → merge step, then HIGH with H=1. If L reaches `IDLE_TIMEOUT` → close period (H,IDLE_TIMEOUT), merge, then FLUSH.
- Merge step: if no pending segment → pending=(H,L,1). If pending (on,off) equals (H,L) and repeat < 2^REP_W−1 → repeat++. Otherwise write pending, pending=(H,L,1).
- FLUSH: write pending, pulse `done`, → IDLE.
- Write: if `fifo_full`=0 → `seg_write`=1 with `seg_data`={on,off,repeat}; else no strobe, `overflow`←1, word lost.
- `abort` (any non-IDLE state) has priority: pending discarded, no write, → IDLE, no `done`.
- `arm` while `busy` ignored. `arm` and `abort` in the same cycle in IDLE: `abort` wins (stay IDLE).

## Timing
- Reset: state IDLE, `seg_write`=0, `seg_data`=0, `busy`=0, `done`=0, `overflow`=0, counters and pending cleared, synchronizer cleared.
- `sig_in` to `s`: 2 cycles latency.
- `busy` rises the cycle after `arm` is sampled; falls the cycle after `done` or `abort`.
- Merge write: `seg_write` registered, asserted the cycle after the closing rising edge of `s`.
- Timeout close: the merge-step write (if any) occurs in the cycle after L reaches `IDLE_TIMEOUT`; the FLUSH write and `done` follow one cycle later. Two back-to-back strobes are therefore possible.
- Counting convention matches the generator: high for H cycles and low for L cycles gives period H+L; a 1-cycle-high, 1-cycle-low signal yields (1,1).

## Test plan
- `IDLE_TIMEOUT`=64: arm, 5 periods of 3 high/7 low, then hold low → writes {3,7,4} then {3,64,1}; `done` pulses once; `busy`=0 afterwards.
- 2 periods (2,2), 3 periods (5,5), then low → writes {2,2,2}, {5,5,2}, {5,64,1}.
- `fifo_full`=1 during the first write of scenario 2 → first word absent, `overflow`=1 and sticky; remaining two words present; next `arm` clears `overflow`.
- `abort` mid-HIGH after 3 closed periods → no further `seg_write`, no `done`, `busy`=0 the next cycle.
- `REP_W`=4 variant (ON_W/OFF_W widened to sum 128): 17 identical (4,4) periods, then low → {4,4,15}, {4,4,1}, {4,64,1}.
- Assert `reset` mid-LOW → all outputs 0 immediately; no write on release; new `arm` captures normally.
